ysyx_24100029_gshare_idx: RTL
=============================

YSYX_24100029_GSHARE_IDX -- requirements
Module: ysyx_24100029_gshare_idx

Interface
REQ-001 Parameter ADDR_W, 32, PC width.
REQ-002 Parameter IDX_W, 3, index width (1..16).
REQ-003 Parameter HIST_W, 8, global history width (2..32).
REQ-004 Parameter PC_SHIFT, 2, low PC bits dropped before folding.
REQ-005 Parameter MODE, 1, 0 = PC-only fold, 1 = gshare (PC fold XOR history fold).
REQ-006 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-007 Port rst_n  in  1  reset, synchronous, active-low.
REQ-008 Port req_valid  in  1  index request valid.
REQ-009 Port req_pc  in  ADDR_W  fetch PC to hash.
REQ-010 Port req_ready  out  1  request accepted when req_valid & req_ready.
REQ-011 Port idx_valid  out  1  registered index valid.
REQ-012 Port idx  out  IDX_W  registered table index.
REQ-013 Port idx_ready  in  1  consumer accepts idx.
REQ-014 Port spec_valid  in  1  speculative branch prediction made.
REQ-015 Port spec_taken  in  1  predicted direction.
REQ-016 Port cmt_valid  in  1  branch retired.
REQ-017 Port cmt_taken  in  1  actual direction of retired branch.
REQ-018 Port flush  in  1  misprediction recovery.
REQ-019 Port ghr_spec  out  HIST_W  speculative history register.
REQ-020 Port ghr_arch  out  HIST_W  architectural history register.

Function
REQ-021 fold_N(x) SHALL give bit k = XOR of every x[i] with (i mod IDX_W) == IDX_W-1-k, over all N bits of x.
REQ-022 Hash input SHALL be req_pc >> PC_SHIFT, zero-extended; no bit of the shifted value dropped.
REQ-023 Index SHALL be fold(req_pc>>PC_SHIFT) when MODE=0, fold(req_pc>>PC_SHIFT) XOR fold(ghr_spec) when MODE=1, using ghr_spec value before this cycle's update.
REQ-024 req_ready SHALL equal (!idx_valid | idx_ready) & !flush, combinationally.
REQ-025 On accepted request, idx and idx_valid=1 SHALL be registered; latency exactly 1 cycle.
REQ-026 While idx_valid & !idx_ready, idx SHALL hold stable; no new request accepted.
REQ-027 idx_valid SHALL clear on idx_ready when no new request is accepted that cycle; back-to-back requests at full throughput.
REQ-028 History shift SHALL be {ghr[HIST_W-2:0], bit}; MSB discarded.
REQ-029 cmt_valid SHALL shift cmt_taken into ghr_arch.
REQ-030 spec_valid & !flush SHALL shift spec_taken into ghr_spec.
REQ-031 flush SHALL load ghr_spec with next ghr_arch (including same-cycle commit shift); spec_valid that cycle ignored.
REQ-032 flush SHALL clear idx_valid next cycle, discarding any pending index.
REQ-033 idx_ready high while idx_valid low SHALL have no effect.

Reset
REQ-034 rst_n low at an edge SHALL set idx_valid=0, idx=0, ghr_spec=0, ghr_arch=0, overriding all other inputs.
REQ-035 req_ready SHALL be 1 in the first cycle after reset deasserts (absent flush).
REQ-036 Reset mid-handshake SHALL drop the pending index without a stale idx_valid pulse.

Verification
REQ-037 Defaults, ghr=0, req_pc=0x8000_0004 -> next cycle idx_valid=1, idx=3'b101.
REQ-038 Two spec_valid taken, then req_pc=0x8000_0004 -> ghr_spec=0x03, idx=3'b011; MODE=0 build gives 3'b101.
REQ-039 idx_ready=0 for 4 cycles with req_valid=1 -> req_ready=0, idx stable, one index delivered on release.
REQ-040 Three spec taken (ghr_spec=0x07, ghr_arch=0), then flush+cmt_valid+cmt_taken=1 -> ghr_arch=0x01, ghr_spec=0x01, idx_valid=0.
REQ-041 Nine commits taken with HIST_W=8 -> ghr_arch=0xFF, MSB wrapped out; one not-taken -> 0xFE.
REQ-042 rst_n low while idx_valid=1 and ghr nonzero -> all outputs zero next cycle, req_ready=1 after release.

Source files
------------

// File: rtl/ysyx_24100029_gshare_idx.sv
// rtl/ysyx_24100029_gshare_idx.sv - gshare branch predictor table index generator with spec/arch history
module ysyx_24100029_gshare_idx #(
    parameter int ADDR_W   = 32,
    parameter int IDX_W    = 3,
    parameter int HIST_W   = 8,
    parameter int PC_SHIFT = 2,
    parameter int MODE     = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_pc,
    output logic              req_ready,
    output logic              idx_valid,
    output logic [IDX_W-1:0]  idx,
    input  logic              idx_ready,
    input  logic              spec_valid,
    input  logic              spec_taken,
    input  logic              cmt_valid,
    input  logic              cmt_taken,
    input  logic              flush,
    output logic [HIST_W-1:0] ghr_spec,
    output logic [HIST_W-1:0] ghr_arch
);

    // Common width wide enough for both the shifted PC and the history,
    // so one fold routine serves both (extra zero bits do not change the XOR).
    localparam int FW = (ADDR_W > HIST_W) ? ADDR_W : HIST_W;

    // Bit i of x lands in output bit IDX_W-1-(i mod IDX_W); input bit 0 maps to the MSB.
    function automatic logic [IDX_W-1:0] fold(input logic [FW-1:0] x);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int k = 0; k < IDX_W; k++) begin
            for (int i = 0; i < FW; i++) begin
                if ((i % IDX_W) == (IDX_W - 1 - k)) begin
                    r[k] = r[k] ^ x[i];
                end
            end
        end
        return r;
    endfunction

    logic [ADDR_W-1:0] pc_shifted;
    logic [FW-1:0]     pc_ext;
    logic [FW-1:0]     ghr_ext;
    logic [IDX_W-1:0]  idx_next;
    logic              accept;
    logic [HIST_W-1:0] ghr_arch_next;

    // Hash of the incoming PC, optionally mixed with the pre-update speculative history.
    always_comb begin
        pc_shifted = req_pc >> PC_SHIFT;
        pc_ext     = FW'(pc_shifted);
        ghr_ext    = FW'(ghr_spec);
        if (MODE == 0) begin
            idx_next = fold(pc_ext);
        end else begin
            idx_next = fold(pc_ext) ^ fold(ghr_ext);
        end
    end

    // Handshake: a new request is taken only when the output slot frees up and no flush is in flight.
    always_comb begin
        req_ready     = (!idx_valid || idx_ready) && !flush;
        accept        = req_valid && req_ready;
        ghr_arch_next = cmt_valid ? {ghr_arch[HIST_W-2:0], cmt_taken} : ghr_arch;
    end

    // Output index register: load on accept, drop on consume or flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_valid <= 1'b0;
            idx       <= '0;
        end else if (flush) begin
            idx_valid <= 1'b0;
        end else if (accept) begin
            idx_valid <= 1'b1;
            idx       <= idx_next;
        end else if (idx_ready) begin
            idx_valid <= 1'b0;
        end
    end

    // History registers: arch follows retirement; spec follows predictions and restores from arch on flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_arch <= '0;
            ghr_spec <= '0;
        end else begin
            ghr_arch <= ghr_arch_next;
            if (flush) begin
                ghr_spec <= ghr_arch_next;
            end else if (spec_valid) begin
                ghr_spec <= {ghr_spec[HIST_W-2:0], spec_taken};
            end
        end
    end

endmodule
